// File: rtl/alu_result_stage_if.sv
// alu_result_stage_if: operation bundle in, result/flag bundle out, valid/ready both sides.
// flag_p exists only when ALU_PARITY_FLAG_EN is defined.
interface alu_result_stage_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] add_res;
    logic [3:0] sub_res;
    logic [3:0] and_res;
    logic [3:0] or_res;
    logic [3:0] xor_res;
    logic       add_cout;
    logic       sub_bout;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] result;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;
    logic       flag_n;
    logic       flag_ill;
`ifdef ALU_PARITY_FLAG_EN
    logic       flag_p;
`endif

    modport master (
        output in_valid, op, a, b,
        output add_res, sub_res, and_res, or_res, xor_res,
        output add_cout, sub_bout, out_ready,
        input  in_ready, out_valid, result,
        input  flag_z, flag_c, flag_v, flag_n, flag_ill
`ifdef ALU_PARITY_FLAG_EN
        , input flag_p
`endif
    );

    modport slave (
        input  in_valid, op, a, b,
        input  add_res, sub_res, and_res, or_res, xor_res,
        input  add_cout, sub_bout, out_ready,
        output in_ready, out_valid, result,
        output flag_z, flag_c, flag_v, flag_n, flag_ill
`ifdef ALU_PARITY_FLAG_EN
        , output flag_p
`endif
    );
endinterface

// File: rtl/alu_result_stage.sv
// alu_result_stage: 4-bit ALU result select + flags into a 2-entry output queue.
// Define ALU_PARITY_FLAG_EN to add the even-parity flag_p output.
module alu_result_stage (
    input logic               clk,
    input logic               rst,
    alu_result_stage_if.slave bus
);
`ifdef ALU_PARITY_FLAG_EN
    localparam int W = 10;
`else
    localparam int W = 9;
`endif

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic         wr_ptr;
    logic         rd_ptr;
    logic [W-1:0] mem [2];
    logic [W-1:0] entry;
    logic         push;
    logic         pop;
    logic [3:0]   r;
    logic         z;
    logic         c;
    logic         v;
    logic         n;
    logic         ill;
    logic         unused_bits;

    assign unused_bits = ^{bus.a[2:0], bus.b[2:0]};

    // Handshake flags come straight from the state register only
    assign bus.in_ready  = (state != TWO);
    assign bus.out_valid = (state != EMPTY);
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_comb begin
        r   = 4'b0000;
        c   = 1'b0;
        v   = 1'b0;
        ill = 1'b0;
        unique case (bus.op)
            3'b000: begin
                r = bus.add_res;
                c = bus.add_cout;
                v = (bus.a[3] == bus.b[3]) && (r[3] != bus.a[3]);
            end
            3'b001: begin
                r = bus.sub_res;
                c = bus.sub_bout;
                v = (bus.a[3] != bus.b[3]) && (r[3] != bus.a[3]);
            end
            3'b010:  r = bus.and_res;
            3'b011:  r = bus.or_res;
            3'b100:  r = bus.xor_res;
            default: ill = 1'b1;
        endcase
        z = (r == 4'b0000);
        n = r[3];
    end

`ifdef ALU_PARITY_FLAG_EN
    assign entry = {r, z, c, v, n, ill, ^r};
    assign {bus.result, bus.flag_z, bus.flag_c, bus.flag_v,
            bus.flag_n, bus.flag_ill, bus.flag_p} = mem[rd_ptr];
`else
    assign entry = {r, z, c, v, n, ill};
    assign {bus.result, bus.flag_z, bus.flag_c, bus.flag_v,
            bus.flag_n, bus.flag_ill} = mem[rd_ptr];
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: if (push) state_nxt = ONE;
            ONE: begin
                if (push && !pop)      state_nxt = TWO;
                else if (pop && !push) state_nxt = EMPTY;
            end
            TWO:     if (pop) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            state <= state_nxt;
            if (push) begin
                mem[wr_ptr] <= entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
        end
    end
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: table-driven vectors plus backpressure,
// streaming and mid-operation reset sequences.
module tb_alu_result_stage;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    alu_result_stage_if bus ();

    alu_result_stage u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] sel;
        logic       cout;
        logic       bout;
        logic [3:0] res;
        logic [4:0] fl;
    } vec_t;

    vec_t tv [12];

    function automatic vec_t mk(input logic [2:0] op, input logic [3:0] a,
                                input logic [3:0] b, input logic [3:0] sel,
                                input logic cout, input logic bout,
                                input logic [3:0] res, input logic [4:0] fl);
        vec_t t;
        t.op = op; t.a = a; t.b = b; t.sel = sel;
        t.cout = cout; t.bout = bout; t.res = res; t.fl = fl;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        bus.op       = t.op;
        bus.a        = t.a;
        bus.b        = t.b;
        bus.add_res  = 4'h1;
        bus.sub_res  = 4'h2;
        bus.and_res  = 4'h4;
        bus.or_res   = 4'h9;
        bus.xor_res  = 4'hB;
        bus.add_cout = t.cout;
        bus.sub_bout = t.bout;
        case (t.op)
            3'b000: bus.add_res = t.sel;
            3'b001: bus.sub_res = t.sel;
            3'b010: bus.and_res = t.sel;
            3'b011: bus.or_res  = t.sel;
            3'b100: bus.xor_res = t.sel;
            default: ;
        endcase
    endtask

    function automatic logic [9:0] act_word();
        logic p;
`ifdef ALU_PARITY_FLAG_EN
        p = bus.flag_p;
`else
        p = 1'b0;
`endif
        return {p, bus.result, bus.flag_z, bus.flag_c,
                bus.flag_v, bus.flag_n, bus.flag_ill};
    endfunction

    function automatic logic [9:0] exp_word(input logic [3:0] res,
                                            input logic [4:0] fl);
        logic p;
`ifdef ALU_PARITY_FLAG_EN
        p = ^res;
`else
        p = 1'b0;
`endif
        return {p, res, fl};
    endfunction

    task automatic chk(input string name, input logic [9:0] act,
                       input logic [9:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic push_add(input logic [3:0] val);
        drive(mk(3'b000, 4'h0, 4'h0, val, 1'b0, 1'b0, val, 5'b0));
        bus.in_valid = 1'b1;
    endtask

    function automatic logic [4:0] add_fl(input logic [3:0] val);
        return {val == 4'h0, 1'b0, 1'b0, val[3], 1'b0};
    endfunction

    initial begin
        n_vec = 0;
        n_bad = 0;
        tv[0]  = mk(3'b000, 4'h7, 4'h1, 4'h8, 1'b0, 1'b0, 4'h8, 5'b00110);
        tv[1]  = mk(3'b001, 4'h3, 4'h5, 4'hE, 1'b0, 1'b1, 4'hE, 5'b01010);
        tv[2]  = mk(3'b100, 4'hA, 4'hA, 4'h0, 1'b1, 1'b1, 4'h0, 5'b10000);
        tv[3]  = mk(3'b110, 4'h7, 4'h1, 4'h0, 1'b1, 1'b1, 4'h0, 5'b10001);
        tv[4]  = mk(3'b010, 4'hC, 4'hA, 4'h8, 1'b1, 1'b1, 4'h8, 5'b00010);
        tv[5]  = mk(3'b011, 4'h3, 4'h4, 4'h7, 1'b0, 1'b0, 4'h7, 5'b00000);
        tv[6]  = mk(3'b000, 4'h8, 4'h8, 4'h0, 1'b1, 1'b0, 4'h0, 5'b11100);
        tv[7]  = mk(3'b001, 4'h8, 4'h1, 4'h7, 1'b0, 1'b0, 4'h7, 5'b00100);
        tv[8]  = mk(3'b101, 4'h8, 4'h1, 4'h0, 1'b1, 1'b1, 4'h0, 5'b10001);
        tv[9]  = mk(3'b111, 4'hF, 4'hF, 4'h0, 1'b1, 1'b1, 4'h0, 5'b10001);
        tv[10] = mk(3'b000, 4'h2, 4'h3, 4'h5, 1'b0, 1'b0, 4'h5, 5'b00000);
        tv[11] = mk(3'b001, 4'h5, 4'h5, 4'h0, 1'b0, 1'b0, 4'h0, 5'b10000);

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(tv[0]);
        @(negedge clk);
        chk("reset_out_valid", {9'b0, bus.out_valid}, 10'd0);
        chk("reset_in_ready", {9'b0, bus.in_ready}, 10'd1);
        chk("reset_data", act_word(), 10'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table: each vector pushed while the previous one pops
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(tv[i]);
            bus.in_valid = 1'b1;
            @(negedge clk);
            bus.in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i),
                {8'b0, bus.out_valid, bus.in_ready}, 10'b11);
            chk($sformatf("vec%0d_data", i), act_word(),
                exp_word(tv[i].res, tv[i].fl));
        end
        @(negedge clk);
        chk("drain_empty", {9'b0, bus.out_valid}, 10'd0);

        // Backpressure: three back-to-back pushes with out_ready low
        bus.out_ready = 1'b0;
        push_add(4'h2);
        @(negedge clk);
        chk("bp_ready1", {9'b0, bus.in_ready}, 10'd1);
        push_add(4'h3);
        @(negedge clk);
        chk("bp_full", {8'b0, bus.out_valid, bus.in_ready}, 10'b10);
        push_add(4'h4);
        @(negedge clk);
        chk("bp_hold_ready", {9'b0, bus.in_ready}, 10'd0);
        chk("bp_head_stable", act_word(), exp_word(4'h2, add_fl(4'h2)));
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_second", act_word(), exp_word(4'h3, add_fl(4'h3)));
        chk("bp_ready_back", {8'b0, bus.out_valid, bus.in_ready}, 10'b11);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bp_third", act_word(), exp_word(4'h4, add_fl(4'h4)));
        chk("bp_third_valid", {9'b0, bus.out_valid}, 10'd1);
        @(negedge clk);
        chk("bp_empty", {9'b0, bus.out_valid}, 10'd0);

        // Streaming: count held at 1 with push and pop every cycle
        push_add(4'h1);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stream%0d_ctl", k),
                {8'b0, bus.out_valid, bus.in_ready}, 10'b11);
            chk($sformatf("stream%0d_data", k), act_word(),
                exp_word(4'(k + 1), add_fl(4'(k + 1))));
            push_add(4'(k + 2));
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("stream_empty", {9'b0, bus.out_valid}, 10'd0);

        // Reset with two entries queued
        bus.out_ready = 1'b0;
        push_add(4'h9);
        @(negedge clk);
        push_add(4'hA);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("rst_pre_full", {9'b0, bus.in_ready}, 10'd0);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_ctl", {8'b0, bus.out_valid, bus.in_ready}, 10'b01);
        chk("rst_async_data", act_word(), 10'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("rst_stay_empty", {9'b0, bus.out_valid}, 10'd0);
        drive(tv[5]);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("rst_repush", act_word(), exp_word(4'h7, 5'b00000));
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
